kadd_sum_checker: RTL
=====================

# kadd_sum_checker

Result-side monitor for the 2-input K-add cell: it consumes the same operand stream that drives the adder, predicts each registered sum, and compares it with the adder's `Sum` after the adder's pipeline latency. The block sits beside the K-add cell in simulation benches and on-chip self-test wrappers. It reports per-sample mismatches, running pass and error counts, and the first failing vector. A start/stop state machine brackets each check run.

## Interface
Parameters:
- `WIDTH`, 2, operand and sum width in bits.
- `LATENCY`, 1, adder clock cycles from operand sample to valid `Sum`; legal range 1..8.
- `CNT_W`, 16, width of the pass and error counters.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a run.
- `stop`  in  1  one-cycle request to end a run.
- `in_valid`  in  1  `a`/`b` carry a sample this cycle.
- `a`, `b`  in  WIDTH  operands, identical to the adder's `A`/`B`.
- `sum`  in  WIDTH  the adder's `Sum` output.
- `busy`  out  1  high in RUN and DRAIN.
- `done`  out  1  one-cycle pulse on the DRAIN→IDLE transition.
- `mismatch`  out  1  one-cycle pulse for each failed compare.
- `pass_count`, `err_count`  out  CNT_W  saturating counters.
- `first_err_valid`  out  1  a first error has been captured.
- `first_err_exp`, `first_err_got`  out  WIDTH  expected and received sums of the first error.

## Operation
- Expected sum: `(a + b) mod 2^WIDTH`. The carry is discarded to match the adder.
- Delay line: LATENCY stages of {valid, expected}. A sample is pushed when `in_valid && state==RUN`. Otherwise a bubble (valid=0) is pushed.
- Compare: when the last stage is valid and the state is RUN or DRAIN:
  - If `sum` equals the expected value, `pass_count` increments.
  - Otherwise `err_count` increments and `mismatch` pulses.
  - If `first_err_valid` is 0, the first error is captured (`first_err_exp`, `first_err_got`) and `first_err_valid` is set.
- Counters saturate at `2^CNT_W-1` and never wrap.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE: `start` clears the counters, the first-error capture and the delay line, then moves to RUN.
  - RUN: `stop` moves to DRAIN.
  - DRAIN: a down-counter loaded with LATENCY runs, with no new pushes. At zero the FSM moves to IDLE and pulses `done`.
- Simultaneous events:
  - `start` and `stop` together in IDLE: `start` wins and `stop` is ignored.
  - `start` in RUN or DRAIN: ignored.
  - `stop` in IDLE or DRAIN: ignored.
- A sample arriving in the same cycle as `stop` is not pushed.
- Samples still in flight at `stop` are compared during DRAIN.
- Results (counters, capture) hold in IDLE until the next `start`.

## Timing
- Reset values: state=IDLE, delay line all invalid, `busy`=0, `done`=0, `mismatch`=0, both counters 0, `first_err_valid`=0, `first_err_exp`=0, `first_err_got`=0.
- Reset is asynchronous. Asserting it mid-run aborts the run immediately and does not pulse `done`.
- Latency:
  - A sample taken on edge k is compared against `sum` sampled on edge k+LATENCY.
  - `mismatch` and the counters update on that same edge and are visible after it.
- `start` is sampled on edge k, `busy` goes high after edge k, and the first sample can be taken on edge k+1.
- For `stop` on edge k, `done` pulses for one cycle after edge k+LATENCY+1 and `busy` drops in the same cycle.

## Structure
- Shared package `kadd_pkg`: FSM state enum (IDLE, RUN, DRAIN), the LATENCY upper bound (8), and a sum-prediction function `kadd_expected(a,b)` so the adder's model and the checker agree.
- One sub-module: `kadd_delay_line`, a parameterised LATENCY-deep shift register of {valid, WIDTH-bit data} with a synchronous clear and an asynchronous reset.
- The FSM, drain counter, compare logic, counters and capture stay in the top module.

## Test plan
- Reset and a correct adder, LATENCY=1. Start, then samples 01+10, 10+11, 11+01, then stop. Expected sums are 11, 01, 00. Required: `pass_count`=3, `err_count`=0, no `mismatch`, `done` 2 cycles after stop.
- Fault injection: force `sum`=10 in place of 01 for the sample 10+11. Required: one `mismatch` pulse, `err_count`=1, `first_err_exp`=01, `first_err_got`=10.
- Stop with data in flight, LATENCY=3: three samples, then `stop` on the cycle after the last one. Required: all three are compared during DRAIN and `pass_count`=3.
- Saturation, CNT_W=4: 20 correct samples. Required: `pass_count` holds at 15.
- Asserting `start` and `stop` together in IDLE gives RUN. `start` during RUN is ignored and the counters are not cleared. Asynchronous reset mid-RUN drops `busy` immediately with no `done` pulse and clears all outputs to their reset values.

Source files
------------

// File: rtl/kadd_pkg.sv
// Shared definitions for the K-add cell and its result checker: FSM states,
// the latency bound and the sum prediction both sides must agree on.
package kadd_pkg;

  localparam int LAT_MAX = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } kadd_state_e;

  // Full-width sum; callers keep the low WIDTH bits (WIDTH <= 32) so the carry drops.
  function automatic logic [31:0] kadd_expected(input logic [31:0] a, input logic [31:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/kadd_delay_line.sv
// DEPTH-stage shift register of {valid, data}; clr empties every stage on the next edge.
module kadd_delay_line #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_data
);

  logic [DEPTH-1:0]            vld_q, vld_d;
  logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;

  always_comb begin
    vld_d     = vld_q;
    data_d    = data_q;
    vld_d[0]  = in_vld;
    data_d[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      vld_d[i]  = vld_q[i-1];
      data_d[i] = data_q[i-1];
    end
    if (clr) begin
      vld_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= '0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign out_vld  = vld_q[DEPTH-1];
  assign out_data = data_q[DEPTH-1];

endmodule

// File: rtl/kadd_sum_checker.sv
// Predicts each K-add sum, aligns it to the adder latency and compares it with
// the adder output, keeping pass/error counts and the first failing vector.
module kadd_sum_checker
  import kadd_pkg::*;
#(
  parameter int WIDTH   = 2,
  parameter int LATENCY = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] sum,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] err_count,
  output logic             first_err_valid,
  output logic [WIDTH-1:0] first_err_exp,
  output logic [WIDTH-1:0] first_err_got
);

  localparam int                DCNT_W     = $clog2(LAT_MAX + 1);
  localparam logic [DCNT_W-1:0] DRAIN_LOAD = DCNT_W'(LATENCY);
  localparam logic [CNT_W-1:0]  CNT_SAT    = '1;

  kadd_state_e       state_q, state_d;
  logic [DCNT_W-1:0] drain_cnt_q, drain_cnt_d;
  logic              done_q, done_d;
  logic              mismatch_q, mismatch_d;
  logic [CNT_W-1:0]  pass_q, pass_d;
  logic [CNT_W-1:0]  err_q, err_d;
  logic              fe_vld_q, fe_vld_d;
  logic [WIDTH-1:0]  fe_exp_q, fe_exp_d;
  logic [WIDTH-1:0]  fe_got_q, fe_got_d;

  logic             push, clr;
  logic [WIDTH-1:0] exp_sum;
  logic             dl_vld;
  logic [WIDTH-1:0] dl_exp;

  assign exp_sum = WIDTH'(kadd_expected(32'(a), 32'(b)));
  // A sample coinciding with stop belongs to no run and is dropped.
  assign push    = in_valid && (state_q == ST_RUN) && !stop;

  kadd_delay_line #(
    .WIDTH (WIDTH),
    .DEPTH (LATENCY)
  ) u_delay (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .in_vld   (push),
    .in_data  (exp_sum),
    .out_vld  (dl_vld),
    .out_data (dl_exp)
  );

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    done_d      = 1'b0;
    mismatch_d  = 1'b0;
    pass_d      = pass_q;
    err_d       = err_q;
    fe_vld_d    = fe_vld_q;
    fe_exp_d    = fe_exp_q;
    fe_got_d    = fe_got_q;
    clr         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          clr      = 1'b1;
          pass_d   = '0;
          err_d    = '0;
          fe_vld_d = 1'b0;
          fe_exp_d = '0;
          fe_got_d = '0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop) begin
          drain_cnt_d = DRAIN_LOAD;
          state_d     = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_q == '0) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          drain_cnt_d = drain_cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Compares never coincide with a start-clear, which only happens in IDLE.
    if (dl_vld && (state_q != ST_IDLE)) begin
      if (sum == dl_exp) begin
        if (pass_q != CNT_SAT) pass_d = pass_q + 1'b1;
      end else begin
        mismatch_d = 1'b1;
        if (err_q != CNT_SAT) err_d = err_q + 1'b1;
        if (!fe_vld_q) begin
          fe_vld_d = 1'b1;
          fe_exp_d = dl_exp;
          fe_got_d = sum;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      drain_cnt_q <= '0;
      done_q      <= 1'b0;
      mismatch_q  <= 1'b0;
      pass_q      <= '0;
      err_q       <= '0;
      fe_vld_q    <= 1'b0;
      fe_exp_q    <= '0;
      fe_got_q    <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      done_q      <= done_d;
      mismatch_q  <= mismatch_d;
      pass_q      <= pass_d;
      err_q       <= err_d;
      fe_vld_q    <= fe_vld_d;
      fe_exp_q    <= fe_exp_d;
      fe_got_q    <= fe_got_d;
    end
  end

  assign busy            = (state_q != ST_IDLE);
  assign done            = done_q;
  assign mismatch        = mismatch_q;
  assign pass_count      = pass_q;
  assign err_count       = err_q;
  assign first_err_valid = fe_vld_q;
  assign first_err_exp   = fe_exp_q;
  assign first_err_got   = fe_got_q;

endmodule
